// File: rtl/sensor_calibration_if.sv
// Bus bundle for sensor_calibration: Avalon-ST sample intake, cal RAM lookup,
// result buffer readout and the downstream ready used to gate intake.
interface sensor_calibration_if;
  logic [15:0] data_in_data;
  logic        data_in_valid;
  logic        data_in_ready;
  logic        data_in_empty;
  logic        data_in_startofpacket;
  logic        data_in_endofpacket;
  logic [8:0]  address;
  logic        clken;
  logic [15:0] cali_fac;
  logic        waitrequest;
  logic [8:0]  data_caled_address;
  logic        data_caled_rd_enable;
  logic [15:0] data_caled;
  logic        to_udp_ready;

  modport slave (
    input  data_in_data, data_in_valid, data_in_empty,
    input  data_in_startofpacket, data_in_endofpacket,
    input  cali_fac, waitrequest,
    input  data_caled_address, data_caled_rd_enable, to_udp_ready,
    output data_in_ready, address, clken, data_caled
  );

  modport master (
    output data_in_data, data_in_valid, data_in_empty,
    output data_in_startofpacket, data_in_endofpacket,
    output cali_fac, waitrequest,
    output data_caled_address, data_caled_rd_enable, to_udp_ready,
    input  data_in_ready, address, clken, data_caled
  );
endinterface

// File: rtl/sensor_calibration.sv
// Per-channel gain calibration: each frame sample is multiplied by its cal RAM
// factor, saturated, and stored in a frame buffer that is read back by address.
module sensor_calibration #(
  parameter int NUM_SAMPLES = 320,
  parameter int FRAC_BITS   = 0
) (
  input  logic clk,
  input  logic rst,
  sensor_calibration_if.slave bus
);
  localparam int ADDR_W = 9;
  localparam int IDX_W  = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_SAMPLES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pendValid_q, pendValid_d;
  logic [15:0]       pendData_q, pendData_d;
  logic [ADDR_W-1:0] pendIdx_q, pendIdx_d;
  logic              capValid_q, capValid_d;
  logic [15:0]       capData_q, capData_d;
  logic [15:0]       capFac_q, capFac_d;
  logic [ADDR_W-1:0] capIdx_q, capIdx_d;
  logic [15:0]       rdData_q, rdData_d;
  logic [15:0]       mem [NUM_SAMPLES];

  logic              stall, ready, accept, takeBeat, inRange, lookup, capture;
  logic [IDX_W-1:0]  sampleIdx;
  logic [31:0]       prod, shifted;
  logic [15:0]       result;
  logic              unusedEmpty;

  assign unusedEmpty = bus.data_in_empty;

  // A lookup waiting on waitrequest blocks new samples so its address stays put.
  assign stall     = pendValid_q && bus.waitrequest;
  assign ready     = bus.to_udp_ready && !stall && !rst;
  assign accept    = bus.data_in_valid && ready;
  assign takeBeat  = accept && (bus.data_in_startofpacket || (state_q == RECV));
  assign sampleIdx = bus.data_in_startofpacket ? '0 : idx_q;
  assign inRange   = sampleIdx < IDX_LIMIT;
  assign lookup    = takeBeat && inRange;
  assign capture   = pendValid_q && !bus.waitrequest;

  assign bus.data_in_ready = ready;
  assign bus.clken         = !rst && (lookup || stall);
  assign bus.address       = rst ? '0 : (lookup ? sampleIdx[ADDR_W-1:0] : pendIdx_q);
  assign bus.data_caled    = rdData_q;

  assign prod    = 32'(capData_q) * 32'(capFac_q);
  assign shifted = prod >> FRAC_BITS;
  assign result  = (|shifted[31:16]) ? 16'hFFFF : shifted[15:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pendValid_d = lookup || stall;
    pendData_d  = pendData_q;
    pendIdx_d   = pendIdx_q;
    capValid_d  = capture;
    capData_d   = capData_q;
    capFac_d    = capFac_q;
    capIdx_d    = capIdx_q;
    rdData_d    = rdData_q;
    if (takeBeat) begin
      state_d = bus.data_in_endofpacket ? IDLE : RECV;
      idx_d   = inRange ? sampleIdx + 1'b1 : sampleIdx;
    end
    if (lookup) begin
      pendData_d = bus.data_in_data;
      pendIdx_d  = sampleIdx[ADDR_W-1:0];
    end
    if (capture) begin
      capData_d = pendData_q;
      capFac_d  = bus.cali_fac;
      capIdx_d  = pendIdx_q;
    end
    if (bus.data_caled_rd_enable) begin
      rdData_d = ({1'b0, bus.data_caled_address} < IDX_LIMIT) ?
                 mem[bus.data_caled_address] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pendValid_q <= 1'b0;
      pendData_q  <= '0;
      pendIdx_q   <= '0;
      capValid_q  <= 1'b0;
      capData_q   <= '0;
      capFac_q    <= '0;
      capIdx_q    <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pendValid_q <= pendValid_d;
      pendData_q  <= pendData_d;
      pendIdx_q   <= pendIdx_d;
      capValid_q  <= capValid_d;
      capData_q   <= capData_d;
      capFac_q    <= capFac_d;
      capIdx_q    <= capIdx_d;
      rdData_q    <= rdData_d;
    end
  end

  // Buffer is not reset; a read of the address being written sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && capValid_q) begin
      mem[capIdx_q] <= result;
    end
  end
endmodule

// File: tb/tb_sensor_calibration.sv
// Self-checking bench for sensor_calibration: random frames against a frame-level
// reference model, with readout responses checked by a scoreboard monitor.
module tb_sensor_calibration;
  localparam int NUM  = 320;
  localparam int FRAC = 0;

  typedef struct {
    logic [15:0] exp;
    bit          care;
    int          addr;
  } rdExp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sensor_calibration_if bus();

  sensor_calibration #(.NUM_SAMPLES(NUM), .FRAC_BITS(FRAC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] calRam [512];
  logic [15:0] expBuf [NUM];
  bit          expKnown [NUM];
  bit          modelInFrame = 1'b0;
  int          modelIdx = 0;
  bit          waitRandom = 1'b0, waitHold = 1'b0, udpRandom = 1'b0, udpHold = 1'b0;
  rdExp_t      sb [$];
  bit          rdSeen = 1'b0, rstSeen = 1'b0, holdKnown = 1'b0;
  logic [15:0] lastExp = 16'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] calib(input logic [15:0] d, input logic [15:0] f);
    longint p;
    p = (longint'(d) * longint'(f)) >>> FRAC;
    return (p > 65535) ? 16'hFFFF : 16'(p);
  endfunction

  // Frame-level reference: which beats land where, independent of pipeline timing.
  function automatic void modelBeat(input logic [15:0] d, input bit sop, input bit eop);
    if (sop) begin
      modelInFrame = 1'b1;
      modelIdx = 0;
    end else if (!modelInFrame) begin
      return;
    end
    if (modelIdx < NUM) begin
      expBuf[modelIdx]   = calib(d, calRam[modelIdx]);
      expKnown[modelIdx] = 1'b1;
      modelIdx++;
    end
    if (eop) modelInFrame = 1'b0;
  endfunction

  function automatic void modelReset();
    modelInFrame = 1'b0;
    modelIdx = 0;
    for (int i = 0; i < NUM; i++) expKnown[i] = 1'b0;
  endfunction

  // Cal RAM: registered read, output valid the cycle after clken.
  always @(posedge clk) begin
    if (bus.clken) bus.cali_fac <= calRam[bus.address];
  end

  always @(negedge clk) begin
    #2;
    bus.waitrequest  = waitHold ? 1'b1 : (waitRandom ? ($urandom_range(0, 3) == 0) : 1'b0);
    bus.to_udp_ready = udpHold ? 1'b0 : (udpRandom ? ($urandom_range(0, 4) != 0) : 1'b1);
  end

  always @(posedge clk) begin
    rdSeen  <= bus.data_caled_rd_enable && !rst;
    rstSeen <= rst;
  end

  // Scoreboard monitor: one response per read issued, otherwise the output must hold.
  always @(negedge clk) begin
    rdExp_t e;
    if (rstSeen) begin
      checkOutput("reset data_caled", 32'(bus.data_caled), 32'h0);
      lastExp   = 16'h0;
      holdKnown = 1'b1;
    end else if (rdSeen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard underflow: got a read response with no expectation");
      end else begin
        e = sb.pop_front();
        if (e.care) begin
          checkOutput($sformatf("read addr %0d", e.addr), 32'(bus.data_caled), 32'(e.exp));
          lastExp   = e.exp;
          holdKnown = 1'b1;
        end else begin
          holdKnown = 1'b0;
        end
      end
    end else if (holdKnown) begin
      checkOutput("data_caled hold", 32'(bus.data_caled), 32'(lastExp));
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input bit sop, input bit eop);
    int guard = 0;
    bus.data_in_data          = d;
    bus.data_in_startofpacket = sop;
    bus.data_in_endofpacket   = eop;
    bus.data_in_empty         = 1'($urandom);
    bus.data_in_valid         = 1'b1;
    #3;
    while (!bus.data_in_ready) begin
      @(negedge clk);
      #3;
      guard++;
      if (guard > 1000) begin
        checks++;
        errors++;
        $display("[TB] FAIL intake timeout: got ready=0 expected ready=1 within 1000 cycles");
        break;
      end
    end
    modelBeat(d, sop, eop);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int n, input bit rampData);
    for (int i = 0; i < n; i++) begin
      applyStimulus(rampData ? 16'(i) : 16'($urandom), i == 0, i == n - 1);
    end
  endtask

  task automatic drain();
    waitRandom = 1'b0;
    udpRandom  = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic readRange(input int lo, input int hi);
    rdExp_t e;
    for (int a = lo; a <= hi; a++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.data_caled_rd_enable = 1'b0;
        bus.data_caled_address   = 9'($urandom);
        @(negedge clk);
      end
      bus.data_caled_address   = 9'(a);
      bus.data_caled_rd_enable = 1'b1;
      e.addr = a;
      if (a < NUM) begin
        e.care = expKnown[a];
        e.exp  = expBuf[a];
      end else begin
        e.care = 1'b1;
        e.exp  = 16'h0;
      end
      sb.push_back(e);
      @(negedge clk);
    end
    bus.data_caled_rd_enable = 1'b0;
  endtask

  task automatic pulseReset(input int cycles);
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    repeat (cycles) begin
      #3;
      checkOutput("reset data_in_ready", 32'(bus.data_in_ready), 32'h0);
      checkOutput("reset clken", 32'(bus.clken), 32'h0);
      checkOutput("reset address", 32'(bus.address), 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.data_in_data          = '0;
    bus.data_in_valid         = 1'b0;
    bus.data_in_empty         = 1'b0;
    bus.data_in_startofpacket = 1'b0;
    bus.data_in_endofpacket   = 1'b0;
    bus.cali_fac              = '0;
    bus.data_caled_address    = '0;
    bus.data_caled_rd_enable  = 1'b0;
    bus.waitrequest           = 1'b0;
    bus.to_udp_ready          = 1'b1;
    for (int i = 0; i < 512; i++) calRam[i] = 16'(i);
    modelReset();

    @(negedge clk);
    pulseReset(3);

    $display("[TB] ramp frame, cal RAM[i]=i");
    sendFrame(NUM, 1'b1);
    drain();
    readRange(0, NUM + 10);
    readRange(511, 511);

    $display("[TB] ramp frame with downstream pause");
    for (int i = 0; i < NUM; i++) begin
      applyStimulus(16'(i), i == 0, i == NUM - 1);
      if (i == 150) begin
        udpHold = 1'b1;
        repeat (10) begin
          #3;
          checkOutput("paused data_in_ready", 32'(bus.data_in_ready), 32'h0);
          @(negedge clk);
        end
        udpHold = 1'b0;
      end
    end
    drain();
    readRange(0, NUM - 1);

    $display("[TB] waitrequest stall on sample 5");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'(i + 1000), i == 0, 1'b0);
    end
    for (int i = 0; i < NUM; i++) begin
      applyStimulus(16'(i), i == 0, i == NUM - 1);
      if (i == 5) begin
        waitHold = 1'b1;
        repeat (3) begin
          #3;
          checkOutput("stall data_in_ready", 32'(bus.data_in_ready), 32'h0);
          checkOutput("stall address", 32'(bus.address), 32'd5);
          checkOutput("stall clken", 32'(bus.clken), 32'h1);
          @(negedge clk);
        end
        waitHold = 1'b0;
      end
    end
    drain();
    readRange(0, 9);

    $display("[TB] random factors, pre-SOP beats, random backpressure");
    for (int i = 0; i < 512; i++) calRam[i] = 16'($urandom);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h5678, 1'b0, 1'b1);
    applyStimulus(16'h9ABC, 1'b0, 1'b0);
    waitRandom = 1'b1;
    udpRandom  = 1'b1;
    sendFrame(NUM, 1'b0);
    drain();
    readRange(0, NUM - 1);

    $display("[TB] oversize frame then post-EOP junk");
    waitRandom = 1'b1;
    sendFrame(NUM + 10, 1'b0);
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 1'b0, 1'b1);
    drain();
    readRange(0, NUM + 2);

    $display("[TB] mid-frame restart and single-sample frame");
    for (int i = 0; i < 10; i++) applyStimulus(16'($urandom), i == 0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), i == 0, i == 3);
    applyStimulus(16'($urandom), 1'b1, 1'b1);
    drain();
    readRange(0, 12);

    $display("[TB] reset mid-frame then fresh frame");
    waitRandom = 1'b1;
    for (int i = 0; i < 50; i++) applyStimulus(16'($urandom), i == 0, 1'b0);
    pulseReset(2);
    sendFrame(NUM, 1'b0);
    drain();
    readRange(0, NUM - 1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
